// File: rtl/vram_arbiter_if.sv
// -----------------------------------------------------------------------------
// vram_arbiter_if
// Purpose : bundles every handshake and bus signal of the VRAM arbiter.
//           This covers the scanout read port, the host write/read ports and
//           the single-port RAM interface.
// Modports:
//   slave  - the arbiter view. It takes requests and mem_rdata, and drives
//            the responses and mem_*.
//   master - the environment view. This is the scanout engine, the host and
//            the RAM.
// Signals :
//   sc_req/sc_addr            scanout read request/address
//   sc_rvalid/sc_rdata        scanout read return
//   host_wr_valid/addr/data   host write request, host_wr_ready accept
//   host_rd_valid/addr        host read request, host_rd_ready accept
//   host_rd_rvalid/rdata      host read return (1-cycle pulse)
//   mem_addr/wdata/we/re      registered RAM command
//   mem_rdata                 RAM data, valid 1 cycle after mem_re
// -----------------------------------------------------------------------------
interface vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              sc_req;
  logic [ADDR_W-1:0] sc_addr;
  logic              sc_rvalid;
  logic [DATA_W-1:0] sc_rdata;
  logic              host_wr_valid;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [DATA_W-1:0] host_wr_data;
  logic              host_wr_ready;
  logic              host_rd_valid;
  logic [ADDR_W-1:0] host_rd_addr;
  logic              host_rd_ready;
  logic              host_rd_rvalid;
  logic [DATA_W-1:0] host_rd_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  sc_req, sc_addr,
    output sc_rvalid, sc_rdata,
    input  host_wr_valid, host_wr_addr, host_wr_data,
    output host_wr_ready,
    input  host_rd_valid, host_rd_addr,
    output host_rd_ready, host_rd_rvalid, host_rd_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  modport master (
    output sc_req, sc_addr,
    input  sc_rvalid, sc_rdata,
    output host_wr_valid, host_wr_addr, host_wr_data,
    input  host_wr_ready,
    output host_rd_valid, host_rd_addr,
    input  host_rd_ready, host_rd_rvalid, host_rd_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Purpose : single-port VRAM arbiter between SVGA scanout and the host bus.
//           Scanout reads always win. Host writes are buffered in a small
//           FIFO and drained in idle slots. A host read is single-outstanding
//           and issues only once the FIFO is empty, so it observes every
//           earlier host write.
// Ports   :
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    vram_arbiter_if.slave (scanout, host and RAM signals)
// -----------------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WFIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  vram_arbiter_if.slave   bus
);

  localparam int                PTR_W   = $clog2(WFIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]    CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]    CNT_MAX = (PTR_W+1)'(WFIFO_DEPTH);

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_PEND = 2'd1,
    RD_WAIT = 2'd2
  } rd_state_e;

  rd_state_e         rd_state_q;
  logic [ADDR_W-1:0] rd_addr_q;

  logic [ADDR_W-1:0] wf_addr_q [WFIFO_DEPTH];
  logic [DATA_W-1:0] wf_data_q [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    cnt_q, cnt_d;

  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q, mem_re_q;

  // Tag pipe: stage 1 is aligned with mem_re, stage 2 with the returning data.
  logic              tag1_sc_q, tag1_host_q;
  logic              sc_rvalid_q, host_rd_rvalid_q;

  logic fifo_empty_s, fifo_full_s;
  logic sc_grant_s, rd_grant_s, wr_grant_s;
  logic wr_ready_s, push_s, rd_accept_s;

  // Slot arbitration and host handshake decode.
  always_comb begin
    fifo_empty_s = (cnt_q == '0);
    fifo_full_s  = (cnt_q == CNT_MAX);
    sc_grant_s   = bus.sc_req;
    rd_grant_s   = !bus.sc_req && (rd_state_q == RD_PEND) && fifo_empty_s;
    wr_grant_s   = !bus.sc_req && !rd_grant_s && !fifo_empty_s;
    // A full FIFO can still take a push in a cycle where its head drains.
    wr_ready_s   = (rd_state_q == RD_IDLE) && (!fifo_full_s || wr_grant_s);
    push_s       = bus.host_wr_valid && wr_ready_s;
    rd_accept_s  = bus.host_rd_valid && (rd_state_q == RD_IDLE);
  end

  // Next FIFO occupancy.
  always_comb begin
    case ({push_s, wr_grant_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Write FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WFIFO_DEPTH; i++) begin
        wf_addr_q[i] <= '0;
        wf_data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_s) begin
        wf_addr_q[wr_ptr_q] <= bus.host_wr_addr;
        wf_data_q[wr_ptr_q] <= bus.host_wr_data;
        wr_ptr_q            <= wr_ptr_q + PTR_ONE;
      end
      if (wr_grant_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      cnt_q <= cnt_d;
    end
  end

  // Host read FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      rd_addr_q  <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (rd_accept_s) begin
            rd_addr_q  <= bus.host_rd_addr;
            rd_state_q <= RD_PEND;
          end
        end
        RD_PEND: begin
          if (rd_grant_s) begin
            rd_state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // The tag reaches stage 2 on this edge, together with the rvalid pulse.
          if (tag1_host_q) begin
            rd_state_q <= RD_IDLE;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  // Registered RAM command and read-return tag pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_we_q         <= 1'b0;
      mem_re_q         <= 1'b0;
      tag1_sc_q        <= 1'b0;
      tag1_host_q      <= 1'b0;
      sc_rvalid_q      <= 1'b0;
      host_rd_rvalid_q <= 1'b0;
    end else begin
      if (sc_grant_s) begin
        mem_addr_q <= bus.sc_addr;
        mem_we_q   <= 1'b0;
        mem_re_q   <= 1'b1;
      end else if (rd_grant_s) begin
        mem_addr_q <= rd_addr_q;
        mem_we_q   <= 1'b0;
        mem_re_q   <= 1'b1;
      end else if (wr_grant_s) begin
        mem_addr_q  <= wf_addr_q[rd_ptr_q];
        mem_wdata_q <= wf_data_q[rd_ptr_q];
        mem_we_q    <= 1'b1;
        mem_re_q    <= 1'b0;
      end else begin
        mem_we_q <= 1'b0;
        mem_re_q <= 1'b0;
      end
      tag1_sc_q        <= sc_grant_s;
      tag1_host_q      <= rd_grant_s;
      sc_rvalid_q      <= tag1_sc_q;
      host_rd_rvalid_q <= tag1_host_q;
    end
  end

  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_re         = mem_re_q;
  assign bus.sc_rvalid      = sc_rvalid_q;
  assign bus.host_rd_rvalid = host_rd_rvalid_q;
  // RAM data is passed through and zeroed outside its valid cycle.
  assign bus.sc_rdata       = sc_rvalid_q      ? bus.mem_rdata : '0;
  assign bus.host_rd_rdata  = host_rd_rvalid_q ? bus.mem_rdata : '0;
  assign bus.host_wr_ready  = wr_ready_s;
  assign bus.host_rd_ready  = (rd_state_q == RD_IDLE);

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Purpose : directed self-checking bench for vram_arbiter, with a simple
//           1-cycle-latency RAM model on the mem_* port.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic seen_s;

  logic [7:0] ram [0:65535];

  vram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  vram_arbiter #(.ADDR_W(16), .DATA_W(8), .WFIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: the preload is applied while reset is held; otherwise reads have 1-cycle latency.
  always @(posedge clk) begin
    if (!rst_n) begin
      ram[16'h0010] <= 8'hA5;
      ram[16'h0200] <= 8'h99;
      ram[16'h0301] <= 8'h5A;
      ram[16'h0400] <= 8'hC3;
    end else begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed test sequence.
  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.sc_req = 1'b0;
    bus.sc_addr = 16'h0000;
    bus.host_wr_valid = 1'b0;
    bus.host_wr_addr = 16'h0000;
    bus.host_wr_data = 8'h00;
    bus.host_rd_valid = 1'b0;
    bus.host_rd_addr = 16'h0000;
    bus.mem_rdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_re", 32'(bus.mem_re), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_rd_ready", 32'(bus.host_rd_ready), 32'd1);
    rst_n = 1'b1;

    // 1: reset while the host read is in RD_WAIT.
    bus.host_rd_valid = 1'b1;
    bus.host_rd_addr = 16'h0010;
    step();
    bus.host_rd_valid = 1'b0;
    step();
    check("t1_issue_re", 32'(bus.mem_re), 32'd1);
    check("t1_wait_rdy", 32'(bus.host_rd_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t1_rst_re", 32'(bus.mem_re), 32'd0);
    check("t1_rst_we", 32'(bus.mem_we), 32'd0);
    check("t1_rst_addr", 32'(bus.mem_addr), 32'd0);
    check("t1_rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("t1_rst_scv", 32'(bus.sc_rvalid), 32'd0);
    check("t1_rst_scd", 32'(bus.sc_rdata), 32'd0);
    check("t1_rst_hrv", 32'(bus.host_rd_rvalid), 32'd0);
    check("t1_rst_hrd", 32'(bus.host_rd_rdata), 32'd0);
    check("t1_rst_rrdy", 32'(bus.host_rd_ready), 32'd1);
    check("t1_rst_wrdy", 32'(bus.host_wr_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen_s = 1'b0;
    repeat (4) begin
      step();
      if (bus.host_rd_rvalid) seen_s = 1'b1;
    end
    check("t1_no_rvalid", 32'(seen_s), 32'd0);
    check("t1_rrdy_after", 32'(bus.host_rd_ready), 32'd1);

    // 2: scanout read latency.
    bus.sc_req = 1'b1;
    bus.sc_addr = 16'h0010;
    step();
    check("t2_re", 32'(bus.mem_re), 32'd1);
    check("t2_addr", 32'(bus.mem_addr), 32'h0010);
    check("t2_scv_early", 32'(bus.sc_rvalid), 32'd0);
    bus.sc_req = 1'b0;
    step();
    check("t2_scv", 32'(bus.sc_rvalid), 32'd1);
    check("t2_scd", 32'(bus.sc_rdata), 32'h00A5);
    check("t2_re_off", 32'(bus.mem_re), 32'd0);
    step();
    check("t2_scv_off", 32'(bus.sc_rvalid), 32'd0);

    // 3: five writes under continuous scanout, then drain in order.
    bus.sc_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.host_wr_valid = 1'b1;
      bus.host_wr_addr = 16'(16'h0100 + i);
      bus.host_wr_data = 8'(8'h10 + i);
      #1;
      check($sformatf("t3_wrdy%0d", i), 32'(bus.host_wr_ready), (i < 4) ? 32'd1 : 32'd0);
      step();
      check($sformatf("t3_nowe%0d", i), 32'(bus.mem_we), 32'd0);
    end
    bus.host_wr_valid = 1'b0;
    bus.sc_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t3_we%0d", i), 32'(bus.mem_we), 32'd1);
      check($sformatf("t3_addr%0d", i), 32'(bus.mem_addr), 32'(16'h0100 + i));
      check($sformatf("t3_data%0d", i), 32'(bus.mem_wdata), 32'(8'h10 + i));
    end
    step();
    check("t3_we_done", 32'(bus.mem_we), 32'd0);

    // 4: read-after-write ordering behind a 3-cycle scanout burst.
    bus.sc_req = 1'b1;
    bus.sc_addr = 16'h0010;
    bus.host_wr_valid = 1'b1;
    bus.host_wr_addr = 16'h0200;
    bus.host_wr_data = 8'h3C;
    step();
    bus.host_wr_valid = 1'b0;
    bus.host_rd_valid = 1'b1;
    bus.host_rd_addr = 16'h0200;
    #1;
    check("t4_rrdy", 32'(bus.host_rd_ready), 32'd1);
    step();
    bus.host_rd_valid = 1'b0;
    step();
    bus.sc_req = 1'b0;
    step();
    check("t4_we", 32'(bus.mem_we), 32'd1);
    check("t4_we_addr", 32'(bus.mem_addr), 32'h0200);
    check("t4_wdata", 32'(bus.mem_wdata), 32'h003C);
    check("t4_we_nore", 32'(bus.mem_re), 32'd0);
    step();
    check("t4_re", 32'(bus.mem_re), 32'd1);
    check("t4_re_addr", 32'(bus.mem_addr), 32'h0200);
    check("t4_re_nowe", 32'(bus.mem_we), 32'd0);
    step();
    check("t4_hrv", 32'(bus.host_rd_rvalid), 32'd1);
    check("t4_hrd", 32'(bus.host_rd_rdata), 32'h003C);
    check("t4_rrdy_back", 32'(bus.host_rd_ready), 32'd1);
    step();
    check("t4_hrv_off", 32'(bus.host_rd_rvalid), 32'd0);

    // 5: scanout, queued write and pending read competing in one cycle.
    bus.sc_req = 1'b1;
    bus.sc_addr = 16'h0400;
    bus.host_wr_valid = 1'b1;
    bus.host_wr_addr = 16'h0300;
    bus.host_wr_data = 8'h77;
    bus.host_rd_valid = 1'b1;
    bus.host_rd_addr = 16'h0301;
    #1;
    check("t5_wrdy", 32'(bus.host_wr_ready), 32'd1);
    check("t5_rrdy", 32'(bus.host_rd_ready), 32'd1);
    step();
    bus.host_wr_valid = 1'b0;
    bus.host_rd_valid = 1'b0;
    step();
    check("t5_sc_re", 32'(bus.mem_re), 32'd1);
    check("t5_sc_addr", 32'(bus.mem_addr), 32'h0400);
    check("t5_sc_nowe", 32'(bus.mem_we), 32'd0);
    bus.sc_req = 1'b0;
    step();
    check("t5_we", 32'(bus.mem_we), 32'd1);
    check("t5_we_addr", 32'(bus.mem_addr), 32'h0300);
    check("t5_wdata", 32'(bus.mem_wdata), 32'h0077);
    check("t5_scv", 32'(bus.sc_rvalid), 32'd1);
    check("t5_scd", 32'(bus.sc_rdata), 32'h00C3);
    step();
    check("t5_re", 32'(bus.mem_re), 32'd1);
    check("t5_re_addr", 32'(bus.mem_addr), 32'h0301);
    step();
    check("t5_hrv", 32'(bus.host_rd_rvalid), 32'd1);
    check("t5_hrd", 32'(bus.host_rd_rdata), 32'h005A);
    step();

    // 6: push and pop together while full, across pointer wrap.
    bus.sc_req = 1'b1;
    bus.sc_addr = 16'h0010;
    for (int i = 0; i < 4; i++) begin
      bus.host_wr_valid = 1'b1;
      bus.host_wr_addr = 16'(16'h0500 + i);
      bus.host_wr_data = 8'(8'hA0 + i);
      step();
    end
    bus.host_wr_addr = 16'h0504;
    bus.host_wr_data = 8'hA4;
    #1;
    check("t6_full_busy", 32'(bus.host_wr_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      bus.sc_req = 1'b0;
      bus.host_wr_valid = 1'b1;
      bus.host_wr_addr = 16'(16'h0504 + k);
      bus.host_wr_data = 8'(8'hA4 + k);
      #1;
      check($sformatf("t6_pp_rdy%0d", k), 32'(bus.host_wr_ready), 32'd1);
      step();
      check($sformatf("t6_pp_we%0d", k), 32'(bus.mem_we), 32'd1);
      check($sformatf("t6_pp_addr%0d", k), 32'(bus.mem_addr), 32'(16'h0500 + k));
      check($sformatf("t6_pp_data%0d", k), 32'(bus.mem_wdata), 32'(8'hA0 + k));
    end
    bus.host_wr_valid = 1'b0;
    bus.sc_req = 1'b1;
    #1;
    check("t6_still_full", 32'(bus.host_wr_ready), 32'd0);
    bus.sc_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t6_dr_we%0d", k), 32'(bus.mem_we), 32'd1);
      check($sformatf("t6_dr_addr%0d", k), 32'(bus.mem_addr), 32'(16'h0503 + k));
      check($sformatf("t6_dr_data%0d", k), 32'(bus.mem_wdata), 32'(8'hA3 + k));
    end
    step();
    check("t6_empty", 32'(bus.mem_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
